mc_cpu_seq: RTL
===============

Name: mc_cpu_seq

Overview:
Parametrised multicycle CPU sequencer. It owns the PC, the register file and the ALU, and drives the stage FSM FETCH, DECODE, EXECUTE, optional MEMORY, WRITEBACK. Instruction and data memory use req/ack handshakes, so each access may take any number of wait states. Non-memory instructions skip the MEMORY stage. Instruction decode is done outside the block: the latched instruction goes out on dec_instr and decoded fields come back on dec_* inputs.

Parameters:
DW, 16, data and register width
AW, 16, PC and memory address width (AW <= DW)
IW, 16, instruction width
NREGS, 8, register count (power of two, >= 2); RW = $clog2(NREGS)
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  clock
rst  in  1  reset
imem_req  out  1  instruction fetch request
imem_addr  out  AW  fetch address (= pc)
imem_ack  in  1  fetch complete, imem_rdata valid
imem_rdata  in  IW  instruction word
dec_instr  out  IW  latched instruction, to external decoder
dec_alu_op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 PASSB
dec_rd, dec_rs1, dec_rs2  in  RW each  register addresses
dec_imm  in  DW  sign-extended immediate
dec_use_imm  in  1  ALU B = imm instead of rs2
dec_reg_write  in  1  write rd in WRITEBACK
dec_wb_mem  in  1  writeback source: 1 = load data, 0 = ALU result
dec_mem_rd, dec_mem_wr  in  1 each  load / store
dec_jump  in  2  00 none, 01 always, 10 if rs1==0, 11 if rs1!=0
dec_halt  in  1  halt instruction
dmem_req  out  1  data request
dmem_we  out  1  1 = store
dmem_addr  out  AW  ALU result [AW-1:0]
dmem_wdata  out  DW  rs2 value
dmem_rdata  in  DW  load data
dmem_ack  in  1  data access complete
pc  out  AW  current PC
retire  out  1  one-cycle pulse per completed instruction
halted  out  1  core is in HALT

Behaviour:
- Reset (async, active-high):
  - state FETCH, pc = RESET_PC, all registers 0.
  - imem_req, dmem_req, dmem_we, retire, halted = 0; dmem_addr/wdata = 0; dec_instr = 0.
  - imem_req rises on the first clock after rst deasserts.
- FETCH:
  - imem_req = 1 while in FETCH.
  - On a clock with imem_ack = 1: latch imem_rdata into dec_instr, drop imem_req on that edge, go to DECODE.
- DECODE (1 cycle):
  - Sample all dec_* inputs.
  - Read rs1 and rs2 into operand latches A and B.
  - Register 0 always reads 0; writes to it are ignored.
- EXECUTE (1 cycle):
  - result = ALU(A, use_imm ? imm : B), truncated to DW, wrap-around.
  - SHL/SHR shift by B[$clog2(DW)-1:0]; SHR is logical.
  - Jump taken per dec_jump, evaluated on A; target = B[AW-1:0].
  - Next state: MEMORY if mem_rd|mem_wr, else WRITEBACK.
  - If mem_rd and mem_wr are both set, the access is treated as a store.
- MEMORY:
  - dmem_req = 1, dmem_we = mem_wr; dmem_addr/dmem_wdata stable until ack.
  - On a clock with dmem_ack = 1: capture dmem_rdata, drop dmem_req, go to WRITEBACK.
  - No timeout: the FSM waits indefinitely.
- WRITEBACK (1 cycle):
  - If reg_write: rd <= wb_mem ? load data : result.
  - pc <= jump taken ? target : pc+1 (mod 2^AW).
  - retire = 1 for this cycle.
  - Next state: HALT if dec_halt, else FETCH.
- HALT: terminal; halted = 1; no requests issued. Only rst exits.
- ack arriving while req = 0 is ignored.
- Reset mid-access drops req immediately. The in-flight access is abandoned and its late ack is ignored unless the FSM is in the matching state.
- Minimum latency: 4 cycles per ALU instruction and 5 per memory instruction, with zero-wait acks (ack high in the same cycle req is asserted).

Optional Feature:
- Macro MC_CPU_SEQ_PERF_EN.
- Defined: adds output ports cycle_cnt[31:0] and instret_cnt[31:0].
  - cycle_cnt increments on every clock when not halted.
  - instret_cnt increments on every retire.
  - Both reset to 0, wrap at 2^32, and freeze while halted.
- Undefined: the ports and counters do not exist.

Decomposition:
- Package mc_cpu_pkg holds:
  - the state enum (FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT);
  - the alu_op_e enum and the jump_e enum;
  - a packed struct ctrl_t bundling the latched dec_* fields.
- One sub-module, mc_regfile: NREGS x DW, two async read ports, one sync write port, r0 hardwired to zero. The ALU stays inline as a case statement.

Test Plan:
- ADD immediate: instruction with rd=1, rs1=0, imm=5, use_imm, reg_write; acks zero-wait. Expect R1=5, retire after 4 cycles, pc 0->1.
- Load with 3 wait states: R2=0x0010, LOAD rd=3, address rs1+imm 0. Expect dmem_req held exactly 4 cycles with dmem_addr 0x0010, rdata 0xBEEF written to R3, retire once.
- Store: rs2=R4=0x1234, address 0x20. Expect dmem_we=1, dmem_wdata 0x1234; no register write.
- Conditional jump: dec_jump=10, R1=0, R2=0x0040. Expect pc=0x0040. Repeat with R1=1: expect pc+1.
- Wrap and r0: pc=0xFFFF non-jump gives pc=0x0000; a write to r0 reads back 0; ADD 0xFFFF+1 gives 0.
- Reset mid-MEMORY, then HALT: assert rst during dmem wait. Expect dmem_req low at once, pc=RESET_PC. Then a HALT instruction gives halted=1 and no further imem_req.

Source files
------------

// File: rtl/mc_cpu_pkg.sv
// mc_cpu_pkg: shared types for the multicycle CPU sequencer (stage states, ALU ops, jump kinds, latched control word)
package mc_cpu_pkg;
  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT} state_e;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SHL, ALU_SHR, ALU_PASSB} alu_op_e;
  typedef enum logic [1:0] {JMP_NONE, JMP_ALWAYS, JMP_EQZ, JMP_NEZ} jump_e;
  typedef struct packed {
    alu_op_e alu_op;
    logic    use_imm;
    logic    reg_write;
    logic    wb_mem;
    logic    mem_rd;
    logic    mem_wr;
    jump_e   jump;
    logic    halt;
  } ctrl_t;
  function automatic logic jump_taken(input jump_e j, input logic zero);
    return j == JMP_ALWAYS || (j == JMP_EQZ && zero) || (j == JMP_NEZ && !zero);
  endfunction
endpackage

// File: rtl/mc_regfile.sv
// mc_regfile: NREGS x DW register file, two async read ports, one sync write port, r0 reads zero
// Ports: clk/rst (async, active-high, clears all registers); we/waddr/wdata write port; raddr1/rdata1, raddr2/rdata2 read ports.
module mc_regfile #(
  parameter int DW    = 16,
  parameter int NREGS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(NREGS)-1:0] waddr,
  input  logic [DW-1:0]            wdata,
  input  logic [$clog2(NREGS)-1:0] raddr1,
  output logic [DW-1:0]            rdata1,
  input  logic [$clog2(NREGS)-1:0] raddr2,
  output logic [DW-1:0]            rdata2
);
  logic [DW-1:0] regs_q [NREGS];
  logic [DW-1:0] regs_d [NREGS];
  always_comb begin
    regs_d = regs_q;
    if (we && waddr != '0) regs_d[waddr] = wdata;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    else regs_q <= regs_d;
  assign rdata1 = raddr1 == '0 ? '0 : regs_q[raddr1];
  assign rdata2 = raddr2 == '0 ? '0 : regs_q[raddr2];
endmodule

// File: rtl/mc_cpu_seq.sv
// mc_cpu_seq: multicycle CPU sequencer (FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT) owning PC, register file and ALU
// Ports: clk/rst (async, active-high); imem_* fetch req/ack; dec_instr out and dec_* decoded fields in;
//        dmem_* data req/ack; pc, retire (pulse per instruction), halted.
// Build option MC_CPU_SEQ_PERF_EN adds cycle_cnt and instret_cnt outputs.
module mc_cpu_seq
  import mc_cpu_pkg::*;
#(
  parameter int            DW       = 16,
  parameter int            AW       = 16,
  parameter int            IW       = 16,
  parameter int            NREGS    = 8,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [AW-1:0]            imem_addr,
  input  logic                     imem_ack,
  input  logic [IW-1:0]            imem_rdata,
  output logic [IW-1:0]            dec_instr,
  input  logic [2:0]               dec_alu_op,
  input  logic [$clog2(NREGS)-1:0] dec_rd,
  input  logic [$clog2(NREGS)-1:0] dec_rs1,
  input  logic [$clog2(NREGS)-1:0] dec_rs2,
  input  logic [DW-1:0]            dec_imm,
  input  logic                     dec_use_imm,
  input  logic                     dec_reg_write,
  input  logic                     dec_wb_mem,
  input  logic                     dec_mem_rd,
  input  logic                     dec_mem_wr,
  input  logic [1:0]               dec_jump,
  input  logic                     dec_halt,
  output logic                     dmem_req,
  output logic                     dmem_we,
  output logic [AW-1:0]            dmem_addr,
  output logic [DW-1:0]            dmem_wdata,
  input  logic [DW-1:0]            dmem_rdata,
  input  logic                     dmem_ack,
  output logic [AW-1:0]            pc,
  output logic                     retire,
  output logic                     halted
`ifdef MC_CPU_SEQ_PERF_EN
  ,
  output logic [31:0]              cycle_cnt,
  output logic [31:0]              instret_cnt
`endif
);
  localparam int RW = $clog2(NREGS);
  localparam int SW = $clog2(DW);
  state_e        state_q, state_d;
  ctrl_t         ctrl_q, ctrl_d;
  logic [AW-1:0] pc_q, pc_d, dmem_addr_q, dmem_addr_d;
  logic [IW-1:0] instr_q, instr_d;
  logic [RW-1:0] rd_q, rd_d;
  logic [DW-1:0] imm_q, imm_d, a_q, a_d, b_q, b_d, result_q, result_d, ld_q, ld_d, dmem_wdata_q, dmem_wdata_d;
  logic          taken_q, taken_d, imem_req_q, imem_req_d, dmem_req_q, dmem_req_d, dmem_we_q, dmem_we_d;
  logic [DW-1:0] rs1_data, rs2_data, op_b, alu_y;
  mc_regfile #(.DW(DW), .NREGS(NREGS)) u_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (state_q == WRITEBACK && ctrl_q.reg_write),
    .waddr  (rd_q),
    .wdata  (ctrl_q.wb_mem ? ld_q : result_q),
    .raddr1 (dec_rs1),
    .rdata1 (rs1_data),
    .raddr2 (dec_rs2),
    .rdata2 (rs2_data)
  );
  always_comb begin
    op_b  = ctrl_q.use_imm ? imm_q : b_q;
    alu_y = op_b;
    case (ctrl_q.alu_op)
      ALU_ADD:   alu_y = a_q + op_b;
      ALU_SUB:   alu_y = a_q - op_b;
      ALU_AND:   alu_y = a_q & op_b;
      ALU_OR:    alu_y = a_q | op_b;
      ALU_XOR:   alu_y = a_q ^ op_b;
      ALU_SHL:   alu_y = a_q << op_b[SW-1:0];
      ALU_SHR:   alu_y = a_q >> op_b[SW-1:0];
      default:   alu_y = op_b;
    endcase
  end
  always_comb begin
    state_d      = state_q;
    ctrl_d       = ctrl_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    rd_d         = rd_q;
    imm_d        = imm_q;
    a_d          = a_q;
    b_d          = b_q;
    result_d     = result_q;
    taken_d      = taken_q;
    ld_d         = ld_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    case (state_q)
      FETCH: if (imem_req_q && imem_ack) begin
        instr_d = imem_rdata;
        state_d = DECODE;
      end
      DECODE: begin
        ctrl_d  = '{alu_op: alu_op_e'(dec_alu_op), use_imm: dec_use_imm, reg_write: dec_reg_write,
                    wb_mem: dec_wb_mem, mem_rd: dec_mem_rd, mem_wr: dec_mem_wr,
                    jump: jump_e'(dec_jump), halt: dec_halt};
        rd_d    = dec_rd;
        imm_d   = dec_imm;
        a_d     = rs1_data;
        b_d     = rs2_data;
        state_d = EXECUTE;
      end
      EXECUTE: begin
        result_d     = alu_y;
        taken_d      = jump_taken(ctrl_q.jump, a_q == '0);
        dmem_addr_d  = alu_y[AW-1:0];
        dmem_wdata_d = b_q;
        state_d      = ctrl_q.mem_rd || ctrl_q.mem_wr ? MEMORY : WRITEBACK;
      end
      MEMORY: if (dmem_req_q && dmem_ack) begin
        ld_d    = dmem_rdata;
        state_d = WRITEBACK;
      end
      WRITEBACK: begin
        pc_d    = taken_q ? b_q[AW-1:0] : pc_q + AW'(1);
        state_d = ctrl_q.halt ? HALT : FETCH;
      end
      default: state_d = HALT;
    endcase
    // Requests are registered off the next state so they rise one clock after reset and drop on the ack edge.
    imem_req_d = state_d == FETCH;
    dmem_req_d = state_d == MEMORY;
    dmem_we_d  = state_d == MEMORY && ctrl_d.mem_wr;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q      <= FETCH;
      ctrl_q       <= '0;
      pc_q         <= RESET_PC;
      instr_q      <= '0;
      rd_q         <= '0;
      imm_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      result_q     <= '0;
      taken_q      <= 1'b0;
      ld_q         <= '0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      imem_req_q   <= 1'b0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ctrl_q       <= ctrl_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      rd_q         <= rd_d;
      imm_q        <= imm_d;
      a_q          <= a_d;
      b_q          <= b_d;
      result_q     <= result_d;
      taken_q      <= taken_d;
      ld_q         <= ld_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      imem_req_q   <= imem_req_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
    end
  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign dec_instr  = instr_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign pc         = pc_q;
  assign retire     = state_q == WRITEBACK;
  assign halted     = state_q == HALT;
`ifdef MC_CPU_SEQ_PERF_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d, instret_cnt_q, instret_cnt_d;
  always_comb begin
    cycle_cnt_d   = halted ? cycle_cnt_q : cycle_cnt_q + 32'd1;
    instret_cnt_d = retire ? instret_cnt_q + 32'd1 : instret_cnt_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`endif
endmodule
